// File: rtl/exec_pkg.sv
// Shared Y86 execute-stage encodings: icodes, ALU/condition ifuns, register IDs, FSM states.
// Pure definitions; no timing or flow control of its own.
package exec_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;
  localparam logic [3:0] ALUMUL = 4'h4;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} mul_state_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  function automatic logic cond_eval(input logic [3:0] fn, input cc_t cc);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (fn)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | cc.zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = cc.zf;
      C_NE:    cond_eval = !cc.zf;
      C_GE:    cond_eval = !lt;
      C_G:     cond_eval = !lt && !cc.zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// Decode-to-execute operands plus the E->M register view and condition codes.
// Upstream holds its fields stable while busy is high; stall/bubble come from downstream.
interface execute_pipe_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [WIDTH-1:0] valC;
  logic [3:0]       dstE;
  logic [3:0]       dstM;
  logic             m_exc;
  logic             stall;
  logic             bubble;
  logic             busy;
  logic             out_valid;
  logic [3:0]       e_icode;
  logic             e_cnd;
  logic [WIDTH-1:0] e_valE;
  logic [WIDTH-1:0] e_valA;
  logic [3:0]       e_dstE;
  logic [3:0]       e_dstM;
  logic             zf;
  logic             sf;
  logic             of;

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, dstE, dstM, m_exc, stall, bubble,
    input  busy, out_valid, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, zf, sf, of
  );

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, dstE, dstM, m_exc, stall, bubble,
    output busy, out_valid, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, zf, sf, of
  );
endinterface

// File: rtl/seq_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle, full 2*WIDTH result.
// WIDTH steps after start; done marks the final step, product is valid from the next cycle.
module seq_mul #(
  parameter int WIDTH = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  assign done    = running && (cnt == CW'(WIDTH - 1));
  assign product = acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end
endmodule

// File: rtl/execute_pipe.sv
// Y86 execute stage: valE, CC register, jXX/cmovXX condition, E->M register; 1 cycle, mulq WIDTH+2.
// busy holds upstream during a multiply; stall holds the E->M register, bubble loads a nop.
module execute_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input logic           clock,
  input logic           reset,
  execute_pipe_if.slave p
);
  localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

  mul_state_e         state, state_nxt;
  cc_t                cc;
  logic               is_mul, mul_start, mul_done, capture, load, cc_we, cnd;
  logic               alu_ok, alu_of;
  logic [WIDTH-1:0]   alu_res, val_e;
  logic [3:0]         dst_e;
  logic [2*WIDTH-1:0] product;

  assign is_mul    = MUL_EN && p.in_valid && (p.icode == IOPQ) && (p.ifun == ALUMUL);
  assign mul_start = (state == S_IDLE) && is_mul;
  // Gated by reset so an aborted multiply releases upstream without waiting for an edge.
  assign p.busy    = !reset && (mul_start || (state == S_MUL));
  assign capture   = p.in_valid && !p.busy;
  assign load      = capture && !p.bubble;

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (p.valA),
    .b       (p.valB),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mul_start) state_nxt = S_MUL;
      S_MUL:   if (mul_done) state_nxt = S_DONE;
      S_DONE:  if (!p.stall) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    alu_ok  = 1'b1;
    case (p.ifun)
      ALUADD: begin
        alu_res = p.valB + p.valA;
        alu_of  = (p.valA[WIDTH-1] == p.valB[WIDTH-1]) && (alu_res[WIDTH-1] != p.valB[WIDTH-1]);
      end
      ALUSUB: begin
        alu_res = p.valB - p.valA;
        alu_of  = (p.valA[WIDTH-1] != p.valB[WIDTH-1]) && (alu_res[WIDTH-1] != p.valB[WIDTH-1]);
      end
      ALUAND: alu_res = p.valB & p.valA;
      ALUXOR: alu_res = p.valB ^ p.valA;
      // Only captured from S_DONE, when the finished product is sitting in the multiplier.
      ALUMUL: begin
        if (MUL_EN) begin
          alu_res = product[WIDTH-1:0];
          alu_of  = |product[2*WIDTH-1:WIDTH];
        end else begin
          alu_ok = 1'b0;
        end
      end
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    val_e = '0;
    case (p.icode)
      IHALT, INOP:      val_e = '0;
      IRRMOVQ:          val_e = p.valA;
      IIRMOVQ:          val_e = p.valC;
      IRMMOVQ, IMRMOVQ: val_e = p.valB + p.valC;
      IPUSHQ, ICALL:    val_e = p.valB - EIGHT;
      IPOPQ, IRET:      val_e = p.valB + EIGHT;
      IOPQ:             val_e = alu_res;
      default:          val_e = '0;
    endcase
  end

  assign cnd   = ((p.icode == IJXX) || (p.icode == IRRMOVQ)) ? cond_eval(p.ifun, cc) : 1'b0;
  assign dst_e = ((p.icode == IRRMOVQ) && !cnd) ? RNONE : p.dstE;
  assign cc_we = capture && !p.stall && !p.m_exc && (p.icode == IOPQ) && alu_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cc <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    end else if (cc_we) begin
      cc.zf <= (alu_res == '0);
      cc.sf <= alu_res[WIDTH-1];
      cc.of <= alu_of;
    end
  end

  assign p.zf = cc.zf;
  assign p.sf = cc.sf;
  assign p.of = cc.of;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p.out_valid <= 1'b0;
      p.e_icode   <= INOP;
      p.e_cnd     <= 1'b0;
      p.e_valE    <= '0;
      p.e_valA    <= '0;
      p.e_dstE    <= RNONE;
      p.e_dstM    <= RNONE;
    end else if (!p.stall) begin
      p.out_valid <= load;
      p.e_icode   <= load ? p.icode : INOP;
      p.e_cnd     <= load ? cnd : 1'b0;
      p.e_valE    <= load ? val_e : '0;
      p.e_valA    <= load ? p.valA : '0;
      p.e_dstE    <= load ? dst_e : RNONE;
      p.e_dstM    <= load ? p.dstM : RNONE;
    end
  end
endmodule

// File: tb/tb_execute_pipe.sv
// Randomized bench for execute_pipe (WIDTH=16) against a cycle-level behavioural model,
// plus directed literal checks on a WIDTH=64 instance.
module tb_execute_pipe;
  import exec_pkg::*;

  localparam int W = 16;
  localparam logic [63:0] MASK = 64'hFFFF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  execute_pipe_if #(.WIDTH(W))  i16 ();
  execute_pipe_if #(.WIDTH(64)) i64 ();

  execute_pipe #(.WIDTH(W),  .MUL_EN(1'b1)) dut   (.clock(clock), .reset(reset), .p(i16));
  execute_pipe #(.WIDTH(64), .MUL_EN(1'b1)) dut64 (.clock(clock), .reset(reset), .p(i64));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference state: expected E->M register, CC, and cycles elapsed in a running multiply.
  logic          m_ov = 1'b0, m_cnd = 1'b0, m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
  logic [3:0]    m_icode = 4'h1, m_dstE = 4'hF, m_dstM = 4'hF;
  logic [W-1:0]  m_valE = '0, m_valA = '0;
  int            m_cyc = 0;

  function automatic logic m_cond(input logic [3:0] fn, input logic z, input logic s, input logic o);
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (s != o) || z;
      4'd2:    return s != o;
      4'd3:    return z;
      4'd4:    return !z;
      4'd5:    return s == o;
      4'd6:    return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    logic        mul_req, busy_x, cap, ok, ofl, c;
    logic [63:0] a, b, cv, r;
    if (reset) begin
      chk("busy_in_reset", {63'd0, i16.busy}, 64'd0);
      m_ov = 0; m_cnd = 0; m_icode = 4'h1; m_dstE = 4'hF; m_dstM = 4'hF;
      m_valE = '0; m_valA = '0; m_zf = 1; m_sf = 0; m_of = 0; m_cyc = 0;
    end else begin
      a  = {48'd0, i16.valA};
      b  = {48'd0, i16.valB};
      cv = {48'd0, i16.valC};
      mul_req = i16.in_valid && i16.icode == 4'h6 && i16.ifun == 4'h4;
      busy_x  = (m_cyc == 0 && mul_req) || (m_cyc >= 1 && m_cyc <= W);
      chk("busy", {63'd0, i16.busy}, {63'd0, busy_x});
      ok = 0; ofl = 0; r = 0;
      case (i16.icode)
        4'h2: r = a;
        4'h3: r = cv;
        4'h4, 4'h5: r = b + cv;
        4'h8, 4'hA: r = b - 64'd8;
        4'h9, 4'hB: r = b + 64'd8;
        4'h6: begin
          ok = 1;
          case (i16.ifun)
            4'h0: begin r = b + a; ofl = (a[W-1] == b[W-1]) && (r[W-1] != b[W-1]); end
            4'h1: begin r = b - a; ofl = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]); end
            4'h2: r = b & a;
            4'h3: r = b ^ a;
            4'h4: begin r = a * b; ofl = (r >> W) != 0; end
            default: ok = 0;
          endcase
        end
        default: r = 0;
      endcase
      r = r & MASK;
      c = (i16.icode == 4'h2 || i16.icode == 4'h7) ? m_cond(i16.ifun, m_zf, m_sf, m_of) : 1'b0;
      cap = i16.in_valid && !busy_x;
      if (cap && !i16.stall && !i16.m_exc && i16.icode == 4'h6 && ok) begin
        m_zf = (r == 0);
        m_sf = r[W-1];
        m_of = ofl;
      end
      if (!i16.stall) begin
        if (cap && !i16.bubble) begin
          m_ov = 1; m_icode = i16.icode; m_cnd = c; m_valE = r[W-1:0]; m_valA = i16.valA;
          m_dstE = (i16.icode == 4'h2 && !c) ? 4'hF : i16.dstE; m_dstM = i16.dstM;
        end else begin
          m_ov = 0; m_icode = 4'h1; m_cnd = 0; m_valE = '0; m_valA = '0; m_dstE = 4'hF; m_dstM = 4'hF;
        end
      end
      if (m_cyc == 0)      m_cyc = mul_req ? 1 : 0;
      else if (m_cyc <= W) m_cyc = m_cyc + 1;
      else if (!i16.stall) m_cyc = 0;
    end
  endtask

  always begin
    @(negedge clock);
    model_step();
    @(posedge clock);
    #1;
    chk("em_cc", {15'd0, i16.out_valid, i16.e_icode, i16.e_cnd, i16.e_valE, i16.e_valA,
                  i16.e_dstE, i16.e_dstM, i16.zf, i16.sf, i16.of},
                 {15'd0, m_ov, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM, m_zf, m_sf, m_of});
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic put16(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    i16.in_valid = v; i16.icode = ic; i16.ifun = fn;
    i16.valA = a; i16.valB = b; i16.valC = c; i16.dstE = de; i16.dstM = dm;
    i16.m_exc = 0; i16.stall = 0; i16.bubble = 0;
  endtask

  task automatic put64(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [3:0] de);
    i64.in_valid = v; i64.icode = ic; i64.ifun = fn;
    i64.valA = a; i64.valB = b; i64.valC = '0; i64.dstE = de; i64.dstM = 4'hF;
    i64.m_exc = 0; i64.stall = 0; i64.bubble = 0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int nb, ne;
    logic [3:0] ic, fn;
    put16(0, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF);
    put64(0, 4'h1, 0, 0, 0, 4'hF);
    cyc(); cyc();
    reset = 0;
    #1;
    chk("reset_state", {50'd0, i16.out_valid, i16.e_icode, i16.e_cnd, i16.e_dstE, i16.e_dstM,
                        i16.zf, i16.sf, i16.of}, {50'd0, 1'b0, 4'h1, 1'b0, 4'hF, 4'hF, 3'b100});
    chk("reset_valE", {48'd0, i16.e_valE}, 64'd0);

    // WIDTH=64 directed: add overflow, then sub to zero feeding jne / cmove.
    put64(1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2);
    cyc();
    chk("w64_add_valE", i64.e_valE, 64'h8000_0000_0000_0000);
    chk("w64_add_cc", {61'd0, i64.out_valid, i64.zf, i64.sf, i64.of}, {61'd0, 4'b1011});
    put64(1, 4'h6, 4'h1, 64'd5, 64'd5, 4'h3);
    cyc();
    chk("w64_sub_valE", i64.e_valE, 64'd0);
    chk("w64_sub_zf", {63'd0, i64.zf}, 64'd1);
    put64(1, 4'h7, 4'h4, 64'd0, 64'd0, 4'hF);
    cyc();
    chk("w64_jne_cnd", {63'd0, i64.e_cnd}, 64'd0);
    put64(1, 4'h2, 4'h3, 64'h55, 64'd0, 4'h6);
    cyc();
    chk("w64_cmove", {55'd0, i64.e_cnd, i64.e_dstE, i64.e_valE[3:0]}, {55'd0, 1'b1, 4'h6, 4'h5});
    put64(0, 4'h1, 0, 0, 0, 4'hF);

    // WIDTH=16 directed.
    put16(1, 4'h6, 4'h0, 16'h7FFF, 16'h0001, 0, 4'h2, 4'hF);
    cyc();
    chk("add16_valE", {48'd0, i16.e_valE}, 64'h8000);
    chk("add16_cc", {61'd0, i16.zf, i16.sf, i16.of}, 64'b011);

    put16(1, 4'h6, 4'h4, 16'd300, 16'd300, 0, 4'h5, 4'hF);
    nb = 0; ne = 0;
    #1;
    for (int k = 0; k < 40; k++) begin
      if (i16.busy) nb++;
      cyc();
      ne++;
      if (i16.out_valid) break;
    end
    chk("mul_busy_cycles", 64'(nb), 64'd17);
    chk("mul_out_edges", 64'(ne), 64'(W + 2));
    chk("mul_valE", {48'd0, i16.e_valE}, 64'h5F90);
    chk("mul_cc", {61'd0, i16.zf, i16.sf, i16.of}, 64'b001);
    put16(0, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF);
    cyc();

    put16(1, 4'h6, 4'h0, 16'h8000, 16'h8000, 0, 4'h1, 4'hF);
    i16.m_exc = 1;
    cyc();
    chk("mexc_valE", {47'd0, i16.out_valid, i16.e_valE}, {47'd0, 1'b1, 16'h0000});
    chk("mexc_cc_kept", {61'd0, i16.zf, i16.sf, i16.of}, 64'b001);

    put16(1, 4'h3, 4'h0, 0, 0, 16'h1234, 4'h2, 4'hF);
    cyc();
    chk("irmov_valE", {48'd0, i16.e_valE}, 64'h1234);
    put16(1, 4'h3, 4'h0, 0, 0, 16'h4321, 4'h7, 4'hF);
    i16.stall = 1; i16.bubble = 1;
    cyc();
    chk("stall_bubble_hold", {43'd0, i16.out_valid, i16.e_valE, i16.e_dstE},
                             {43'd0, 1'b1, 16'h1234, 4'h2});
    put16(1, 4'h3, 4'h0, 0, 0, 16'h4321, 4'h7, 4'hF);
    i16.bubble = 1;
    cyc();
    chk("bubble_nop", {59'd0, i16.out_valid, i16.e_dstE}, {59'd0, 1'b0, 4'hF});

    put16(1, 4'h6, 4'h4, 16'd123, 16'd45, 0, 4'h3, 4'hF);
    repeat (5) cyc();
    chk("mul_mid_busy", {63'd0, i16.busy}, 64'd1);
    reset = 1;
    put16(0, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF);
    #1;
    chk("rst_busy_drop", {62'd0, i16.busy, i16.out_valid}, 64'd0);
    cyc(); cyc();
    reset = 0;
    #1;
    chk("rst_mid_state", {31'd0, i16.out_valid, i16.e_icode, i16.e_valE, i16.e_dstE, i16.zf, i16.sf, i16.of, i16.busy},
                         {31'd0, 1'b0, 4'h1, 16'h0000, 4'hF, 3'b100, 1'b0});
    put16(1, 4'h6, 4'h0, 16'd3, 16'd2, 0, 4'h4, 4'hF);
    cyc();
    chk("post_rst_add", {48'd0, i16.e_valE}, 64'd5);

    // Random traffic; instruction fields are held while a multiply is in flight.
    for (int n = 0; n < 1500; n++) begin
      if (m_cyc == 0) begin
        ic = ($urandom_range(0, 3) == 0) ? 4'h6 : 4'($urandom_range(0, 11));
        fn = 4'($urandom_range(0, 7));
        if (fn == 4'h4 && $urandom_range(0, 2) != 0) fn = 4'h0;
        put16($urandom_range(0, 7) != 0, ic, fn, pick(), pick(), pick(),
              4'($urandom), 4'($urandom));
      end
      i16.m_exc  = ($urandom_range(0, 7) == 0);
      i16.stall  = ($urandom_range(0, 7) == 0);
      i16.bubble = ($urandom_range(0, 7) == 0);
      cyc();
    end
    put16(0, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF);
    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
